ifc_z_collector: RTL and testbench
==================================

Name: ifc_z_collector

Overview:
- Downstream consumer of the 8-bit IFC_Z result produced by the interface compute entity.
- Collects Z samples under a valid/ready handshake into fixed windows of WIN samples.
- Emits one registered record per window: wrapped sum, maximum and window index.
- Decouples the combinational Z producer from the register-based result sink.

Parameters:
- DATA_W, 8, width of the incoming Z sample.
- SUM_W, 16, width of the window sum accumulator and output.
- WIN, 4, samples per window; legal range 2..256.
- IDX_W, 8, width of the window index counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous reset, active-low.
- IN_Z  in  DATA_W  Z sample from the compute stage.
- IN_VALID  in  1  IN_Z is valid this cycle.
- IN_READY  out  1  collector accepts IN_Z this cycle.
- OUT_SUM  out  SUM_W  sum of the completed window.
- OUT_MAX  out  DATA_W  largest sample in the completed window.
- OUT_IDX  out  IDX_W  window sequence number, starting at 0.
- OUT_VALID  out  1  output record is valid.
- OUT_READY  in  1  sink consumes the record.
- OUT_OVF  out  1  sum saturated in this window (see Optional Feature).

Behaviour:
- One clock domain. Reset is synchronous, active-low, named RST_N, and is sampled on the CLK rising edge.
- Reset (RST_N=0 at an edge) clears the following: accumulator, running max, sample count, OUT_SUM=0, OUT_MAX=0, OUT_IDX=0, OUT_VALID=0, OUT_OVF=0, state=ACC.
- While RST_N=0, IN_READY=0.
- An accept occurs when IN_VALID && IN_READY. An output handshake occurs when OUT_VALID && OUT_READY.
- States:
  - ACC: collecting samples; count is in 0..WIN-1.
  - STALL: the window is complete, but the output register is still holding an unconsumed record.
- IN_READY=1 in ACC, except when count==WIN-1, OUT_VALID=1 and OUT_READY=0; in that case IN_READY=0. This is a combinational look-ahead, so the last sample is not accepted into a blocked output.
- Accept with count<WIN-1:
  - acc <= acc + zero-extended IN_Z, modulo 2^SUM_W.
  - max <= larger of max and IN_Z.
  - count <= count+1.
- Accept with count==WIN-1 (window close), in the same edge:
  - OUT_SUM <= acc + IN_Z; OUT_MAX <= larger of max and IN_Z; OUT_VALID <= 1.
  - OUT_IDX <= window counter; window counter increments, wrapping at 2^IDX_W.
  - acc, max and count clear to 0.
- Output handshake with no window close in the same cycle: OUT_VALID <= 0.
- Output handshake and window close in the same cycle: the new record loads and OUT_VALID stays 1. This gives full throughput of one record per WIN cycles with no bubble.
- The output record is stable while OUT_VALID=1 and OUT_READY=0.
- STALL is entered when count==WIN-1, IN_VALID=1 and the output is blocked. It returns to ACC on the cycle after OUT_READY rises.
- Latency: record valid 1 cycle after the accept of the last sample of its window.
- Max is unsigned. The first sample of a window always replaces the cleared max, so OUT_MAX=0 only when all samples are 0.
- Reset mid-window discards the partial window and any pending output record. The window counter restarts at 0.
- IN_VALID=0 does not advance count; gaps inside a window are allowed.

Optional Feature:
- Macro: IFC_Z_COLLECTOR_SAT_EN.
- Defined:
  - The accumulator saturates at 2^SUM_W-1 instead of wrapping.
  - A sticky per-window overflow bit is set when saturation occurs.
  - The overflow bit is copied to OUT_OVF at window close and cleared with the accumulator.
- Undefined:
  - Sum wraps modulo 2^SUM_W.
  - OUT_OVF is constant 0.
  - No saturation logic is synthesised.

Test Plan:
1. WIN=4, OUT_READY=1, IN_Z=1,2,3,4 on consecutive cycles -> one cycle later OUT_VALID=1, OUT_SUM=10, OUT_MAX=4, OUT_IDX=0; second window 5,5,5,5 -> OUT_SUM=20, OUT_MAX=5, OUT_IDX=1, no gap cycle.
2. OUT_READY=0 after the first record, stream 8 more samples -> 3 accepted; on the 4th, IN_READY=0 and state is STALL; record 0 stays stable. Raise OUT_READY for 1 cycle -> 4th sample accepted next cycle; record 1 appears; no sample lost or duplicated.
3. IN_VALID toggled 1,0,1,0 with IN_Z=7,x,9,x,3,x,1 -> record only after the 4th accept, with OUT_SUM=20 and OUT_MAX=9.
4. SUM_W=8, samples 200,100,0,0:
   - Without macro -> OUT_SUM=44, OUT_OVF=0.
   - With IFC_Z_COLLECTOR_SAT_EN -> OUT_SUM=255, OUT_OVF=1; the next window 1,1,1,1 gives OUT_SUM=4, OUT_OVF=0.
5. Accept 2 samples, then RST_N=0 for 1 cycle, then 4 samples of 2 -> OUT_SUM=8, OUT_IDX=0, and OUT_VALID=0 during and right after reset.
6. IDX_W=2, run 5 windows with OUT_READY=1 -> OUT_IDX sequence 0,1,2,3,0.

Source files
------------

// File: rtl/ifc_z_collector.sv
// Windowed Z-sample collector: accumulates WIN samples per window and emits a
// registered {sum, max, index} record. Optional saturation: IFC_Z_COLLECTOR_SAT_EN.
module ifc_z_collector #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16,
    parameter int WIN    = 4,
    parameter int IDX_W  = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] IN_Z,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [SUM_W-1:0]  OUT_SUM,
    output logic [DATA_W-1:0] OUT_MAX,
    output logic [IDX_W-1:0]  OUT_IDX,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              OUT_OVF
);

    localparam int              CNT_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN - 1);

    typedef enum logic [0:0] {ACC, STALL} state_e;

    state_e            state_q, state_d;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0] omax_q, omax_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              vld_q, vld_d;

    logic              is_last, out_hs, in_ready, accept;
    logic [SUM_W-1:0]  acc_next;
    logic [DATA_W-1:0] max_next;

`ifdef IFC_Z_COLLECTOR_SAT_EN
    logic              ovf_q, ovf_d, oovf_q, oovf_d, ovf_next;
    logic [SUM_W:0]    acc_ext;
`endif

    always_comb begin
        is_last  = (cnt_q == LAST);
        out_hs   = vld_q && OUT_READY;
        // Look-ahead: refuse the closing sample while the output record is blocked.
        in_ready = RST_N && (state_q == ACC) && !(is_last && vld_q && !OUT_READY);
        accept   = IN_VALID && in_ready;
        max_next = (IN_Z > max_q) ? IN_Z : max_q;
`ifdef IFC_Z_COLLECTOR_SAT_EN
        acc_ext  = {1'b0, acc_q} + (SUM_W+1)'(IN_Z);
        acc_next = acc_ext[SUM_W] ? '1 : acc_ext[SUM_W-1:0];
        ovf_next = ovf_q | acc_ext[SUM_W];
`else
        acc_next = acc_q + SUM_W'(IN_Z);
`endif
    end

    // NOTE: every _d gets its default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        sum_d   = sum_q;
        omax_d  = omax_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
`ifdef IFC_Z_COLLECTOR_SAT_EN
        ovf_d   = ovf_q;
        oovf_d  = oovf_q;
`endif

        if (accept && is_last) begin
            sum_d  = acc_next;
            omax_d = max_next;
            idx_d  = win_q;
            win_d  = win_q + IDX_W'(1);
            vld_d  = 1'b1;
            acc_d  = '0;
            max_d  = '0;
            cnt_d  = '0;
`ifdef IFC_Z_COLLECTOR_SAT_EN
            oovf_d = ovf_next;
            ovf_d  = 1'b0;
`endif
        end else begin
            if (accept) begin
                acc_d = acc_next;
                max_d = max_next;
                cnt_d = cnt_q + CNT_W'(1);
`ifdef IFC_Z_COLLECTOR_SAT_EN
                ovf_d = ovf_next;
`endif
            end
            if (out_hs) vld_d = 1'b0;
        end

        case (state_q)
            ACC:     if (is_last && IN_VALID && vld_q && !OUT_READY) state_d = STALL;
            STALL:   if (OUT_READY) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on CLK.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ACC;
            acc_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            win_q   <= '0;
            sum_q   <= '0;
            omax_q  <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
`ifdef IFC_Z_COLLECTOR_SAT_EN
            ovf_q   <= 1'b0;
            oovf_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            sum_q   <= sum_d;
            omax_q  <= omax_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
`ifdef IFC_Z_COLLECTOR_SAT_EN
            ovf_q   <= ovf_d;
            oovf_q  <= oovf_d;
`endif
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_SUM   = sum_q;
    assign OUT_MAX   = omax_q;
    assign OUT_IDX   = idx_q;
    assign OUT_VALID = vld_q;
`ifdef IFC_Z_COLLECTOR_SAT_EN
    assign OUT_OVF   = oovf_q;
`else
    assign OUT_OVF   = 1'b0;
`endif

endmodule

// File: tb/tb_ifc_z_collector.sv
// Table-driven bench for ifc_z_collector (WIN=4, SUM_W=8, IDX_W=2 to reach wrap corners).
module tb_ifc_z_collector;

    localparam int DATA_W = 8;
    localparam int SUM_W  = 8;
    localparam int WIN    = 4;
    localparam int IDX_W  = 2;

`ifdef IFC_Z_COLLECTOR_SAT_EN
    localparam logic [SUM_W-1:0] E4_SUM = 8'd255;
    localparam logic             E4_OVF = 1'b1;
`else
    localparam logic [SUM_W-1:0] E4_SUM = 8'd44;
    localparam logic             E4_OVF = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [DATA_W-1:0] IN_Z;
    logic              IN_VALID;
    logic              IN_READY;
    logic [SUM_W-1:0]  OUT_SUM;
    logic [DATA_W-1:0] OUT_MAX;
    logic [IDX_W-1:0]  OUT_IDX;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic              OUT_OVF;

    int checks   = 0;
    int failures = 0;

    ifc_z_collector #(
        .DATA_W(DATA_W), .SUM_W(SUM_W), .WIN(WIN), .IDX_W(IDX_W)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_Z(IN_Z), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .OUT_SUM(OUT_SUM), .OUT_MAX(OUT_MAX),
        .OUT_IDX(OUT_IDX), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_OVF(OUT_OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] z;
        logic              ordy;
        logic              e_rdy;
        logic              e_vld;
        logic [SUM_W-1:0]  e_sum;
        logic [DATA_W-1:0] e_max;
        logic [IDX_W-1:0]  e_idx;
        logic              e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic v, input logic [7:0] z, input logic ordy,
                                input logic e_rdy, input logic e_vld, input logic [7:0] e_sum,
                                input logic [7:0] e_max, input logic [1:0] e_idx,
                                input logic e_ovf);
        vecs.push_back('{v, z, ordy, e_rdy, e_vld, e_sum, e_max, e_idx, e_ovf});
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic apply(input logic v, input logic [DATA_W-1:0] z, input logic ordy);
        @(negedge CLK);
        IN_VALID  = v;
        IN_Z      = z;
        OUT_READY = ordy;
        #1;
    endtask

    task automatic check_out(input string tag, input logic e_vld, input logic [SUM_W-1:0] e_sum,
                             input logic [DATA_W-1:0] e_max, input logic [IDX_W-1:0] e_idx,
                             input logic e_ovf);
        check({tag, ".out_valid"}, 32'(OUT_VALID), 32'(e_vld));
        check({tag, ".out_sum"},   32'(OUT_SUM),   32'(e_sum));
        check({tag, ".out_max"},   32'(OUT_MAX),   32'(e_max));
        check({tag, ".out_idx"},   32'(OUT_IDX),   32'(e_idx));
        check({tag, ".out_ovf"},   32'(OUT_OVF),   32'(e_ovf));
    endtask

    initial begin
        // Each row: inputs for this cycle, outputs expected before the next rising edge.
        // Plan 1: two back-to-back windows with the sink always ready.
        add(1,  1, 1, 1, 0,  0, 0, 0, 0);
        add(1,  2, 1, 1, 0,  0, 0, 0, 0);
        add(1,  3, 1, 1, 0,  0, 0, 0, 0);
        add(1,  4, 1, 1, 0,  0, 0, 0, 0);
        add(1,  5, 1, 1, 1, 10, 4, 0, 0);
        add(1,  5, 1, 1, 0, 10, 4, 0, 0);
        add(1,  5, 1, 1, 0, 10, 4, 0, 0);
        add(1,  5, 1, 1, 0, 10, 4, 0, 0);
        // Plan 2: sink blocked; closing sample refused, STALL, then released for one cycle.
        add(1,  6, 0, 1, 1, 20, 5, 1, 0);
        add(1,  7, 0, 1, 1, 20, 5, 1, 0);
        add(1,  8, 0, 1, 1, 20, 5, 1, 0);
        add(1,  9, 0, 0, 1, 20, 5, 1, 0);
        add(1,  9, 0, 0, 1, 20, 5, 1, 0);
        add(1,  9, 1, 0, 1, 20, 5, 1, 0);
        add(1,  9, 0, 1, 0, 20, 5, 1, 0);
        add(0,  0, 0, 1, 1, 30, 9, 2, 0);
        // Handshake and window close on the same edge: record reloads, valid stays high.
        add(1,  1, 0, 1, 1, 30, 9, 2, 0);
        add(1,  1, 0, 1, 1, 30, 9, 2, 0);
        add(1,  1, 0, 1, 1, 30, 9, 2, 0);
        add(1,  2, 1, 1, 1, 30, 9, 2, 0);
        add(0,  0, 1, 1, 1,  5, 2, 3, 0);
        // Plan 3: gaps inside a window; index wraps 3 -> 0.
        add(1,  7, 1, 1, 0,  5, 2, 3, 0);
        add(0, 99, 1, 1, 0,  5, 2, 3, 0);
        add(1,  9, 1, 1, 0,  5, 2, 3, 0);
        add(0, 99, 1, 1, 0,  5, 2, 3, 0);
        add(1,  3, 1, 1, 0,  5, 2, 3, 0);
        add(0, 99, 1, 1, 0,  5, 2, 3, 0);
        add(1,  1, 1, 1, 0,  5, 2, 3, 0);
        add(0,  0, 1, 1, 1, 20, 9, 0, 0);
        add(0,  0, 1, 1, 0, 20, 9, 0, 0);
        // Plan 4: sum overflow (wrap or saturate), then a clean window clears the flag.
        add(1, 200, 1, 1, 0, 20, 9, 0, 0);
        add(1, 100, 1, 1, 0, 20, 9, 0, 0);
        add(1,   0, 1, 1, 0, 20, 9, 0, 0);
        add(1,   0, 1, 1, 0, 20, 9, 0, 0);
        add(1,   1, 1, 1, 1, E4_SUM, 200, 1, E4_OVF);
        add(1,   1, 1, 1, 0, E4_SUM, 200, 1, E4_OVF);
        add(1,   1, 1, 1, 0, E4_SUM, 200, 1, E4_OVF);
        add(1,   1, 1, 1, 0, E4_SUM, 200, 1, E4_OVF);
        add(0,   0, 0, 1, 1,  4, 1, 2, 0);

        RST_N = 1'b0; IN_VALID = 1'b0; IN_Z = '0; OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset.in_ready", 32'(IN_READY), 32'd0);
        check_out("reset", 0, 0, 0, 0, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].v, vecs[i].z, vecs[i].ordy);
            check($sformatf("row%0d.in_ready", i), 32'(IN_READY), 32'(vecs[i].e_rdy));
            check_out($sformatf("row%0d", i), vecs[i].e_vld, vecs[i].e_sum,
                      vecs[i].e_max, vecs[i].e_idx, vecs[i].e_ovf);
        end

        // Plan 5: pending record plus partial window, then a one-cycle reset.
        apply(1, 5, 0);
        apply(1, 5, 0);
        check("rst5.pre_valid", 32'(OUT_VALID), 32'd1);
        @(negedge CLK);
        RST_N = 1'b0; IN_VALID = 1'b1; IN_Z = 8'd5; #1;
        check("rst5.in_ready_during", 32'(IN_READY), 32'd0);
        check("rst5.valid_during", 32'(OUT_VALID), 32'd1);
        @(negedge CLK);
        RST_N = 1'b1; IN_VALID = 1'b0; #1;
        check_out("rst5.after", 0, 0, 0, 0, 0);
        for (int i = 0; i < WIN; i++) begin
            apply(1, 2, 1);
            check($sformatf("rst5.in_ready%0d", i), 32'(IN_READY), 32'd1);
            check($sformatf("rst5.valid%0d", i), 32'(OUT_VALID), 32'd0);
        end
        apply(0, 0, 1);
        check_out("rst5.rec", 1, 8, 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
